// File: rtl/platform_pio_display_mux.sv
// platform_pio_display_mux
// Avalon-MM slave driving a time-multiplexed seven-segment display.
// Per-digit data registers, optional hex decode, per-digit blanking,
// global blink, and a one-cycle blank gap at every digit change so the
// previous digit's pattern never ghosts onto the newly selected digit.

module platform_pio_display_mux #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [7:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_sel
);

   localparam int              PW          = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]   PRESC_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [2:0]      IDX_LAST    = 3'(NUM_DIGITS - 1);
   localparam logic [7:0]      DIGIT_MASK  = 8'((9'd1 << NUM_DIGITS) - 9'd1);
   localparam logic [7:0]      SEG_OFF     = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF =
      (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [3:0]      ADDR_CTRL   = 4'd8;
   localparam logic [3:0]      ADDR_PERIOD = 4'd9;
   localparam logic [3:0]      ADDR_STATUS = 4'd10;

   // Hex nibble to active-high a..g pattern.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Bus-visible registers. Entries of digit_r beyond NUM_DIGITS stay zero.
   logic [7:0]            digit_r [8];
   logic                  enable_r;
   logic                  hex_mode_r;
   logic                  blink_en_r;
   logic [7:0]            blank_mask_r;
   logic [15:0]           blink_period_r;

   // Scanner and blink state.
   logic [PW-1:0]         presc_r;
   logic [2:0]            index_r;
   logic                  gap_r;
   logic [15:0]           blink_cnt_r;
   logic                  phase_r;

   logic                  wr_s;
   logic                  ctrl_wr_s;
   logic                  period_wr_s;
   logic                  run_s;
   logic                  presc_tc_s;
   logic                  frame_tc_s;
   logic [7:0]            cur_digit_s;
   logic [7:0]            pattern_s;
   logic [NUM_DIGITS-1:0] select_s;
   logic                  unused_s;

   assign wr_s        = chipselect & ~write_n;
   assign ctrl_wr_s   = wr_s & (address == ADDR_CTRL);
   assign period_wr_s = wr_s & (address == ADDR_PERIOD);
   // A CTRL write that clears enable stops the counters on the same edge,
   // overriding any advance due on that edge.
   assign run_s       = enable_r & ~(ctrl_wr_s & ~writedata[0]);
   assign presc_tc_s  = (presc_r == PRESC_LAST);
   assign frame_tc_s  = presc_tc_s & (index_r == IDX_LAST);
   assign cur_digit_s = digit_r[index_r];
   assign unused_s    = ^writedata[31:16];

   // Register file writes from the bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            digit_r[i] <= 8'h00;
         end
         enable_r       <= 1'b0;
         hex_mode_r     <= 1'b0;
         blink_en_r     <= 1'b0;
         blank_mask_r   <= 8'h00;
         blink_period_r <= 16'h0000;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_s && (address == 4'(i)) && (i < NUM_DIGITS)) begin
               digit_r[i] <= writedata[7:0];
            end
         end
         if (ctrl_wr_s) begin
            enable_r     <= writedata[0];
            hex_mode_r   <= writedata[1];
            blink_en_r   <= writedata[2];
            blank_mask_r <= writedata[15:8] & DIGIT_MASK;
         end
         if (period_wr_s) begin
            blink_period_r <= writedata[15:0];
         end
      end
   end

   // Prescaler and digit index; gap_r marks the slot just after an index step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r <= {PW{1'b0}};
         index_r <= 3'd0;
         gap_r   <= 1'b0;
      end else if (!run_s) begin
         presc_r <= {PW{1'b0}};
         index_r <= 3'd0;
         gap_r   <= 1'b0;
      end else begin
         gap_r <= presc_tc_s;
         if (presc_tc_s) begin
            presc_r <= {PW{1'b0}};
            index_r <= (index_r == IDX_LAST) ? 3'd0 : index_r + 3'd1;
         end else begin
            presc_r <= presc_r + PW'(1'b1);
         end
      end
   end

   // Blink counter counts frames and toggles the phase every half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_r <= 16'h0000;
         phase_r     <= 1'b0;
      end else if (!run_s || period_wr_s || (blink_period_r == 16'h0000)) begin
         blink_cnt_r <= 16'h0000;
         phase_r     <= 1'b0;
      end else if (frame_tc_s) begin
         if (blink_cnt_r == (blink_period_r - 16'd1)) begin
            blink_cnt_r <= 16'h0000;
            phase_r     <= ~phase_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + 16'd1;
         end
      end
   end

   // Active-high pattern and digit select for the current slot.
   always_comb begin
      pattern_s = 8'h00;
      select_s  = {NUM_DIGITS{1'b0}};
      if (enable_r && !gap_r) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            select_s[i] = (index_r == 3'(i));
         end
         if (blank_mask_r[index_r] || (blink_en_r && phase_r)) begin
            pattern_s = 8'h00;
         end else if (hex_mode_r) begin
            pattern_s = {cur_digit_s[7], hex7(cur_digit_s[3:0])};
         end else begin
            pattern_s = cur_digit_s;
         end
      end else begin
         pattern_s = 8'h00;
         select_s  = {NUM_DIGITS{1'b0}};
      end
   end

   // Output registers apply pin polarity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_out <= SEG_OFF;
         dig_sel <= DIG_OFF;
      end else begin
         seg_out <= (SEG_ACTIVE_LOW != 0) ? ~pattern_s : pattern_s;
         dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~select_s : select_s;
      end
   end

   // Zero-latency read mux; unmapped addresses read zero.
   always_comb begin
      readdata = 32'h0000_0000;
      if (address < 4'(NUM_DIGITS)) begin
         readdata = {24'h000000, digit_r[address[2:0]]};
      end else begin
         case (address)
            ADDR_CTRL:   readdata = {16'h0000, blank_mask_r, 5'b00000,
                                     blink_en_r, hex_mode_r, enable_r};
            ADDR_PERIOD: readdata = {16'h0000, blink_period_r};
            ADDR_STATUS: readdata = {28'h0000000, phase_r, index_r};
            default:     readdata = 32'h0000_0000;
         endcase
      end
   end

endmodule

// File: doc/platform_pio_display_mux.md
# platform_pio_display_mux

Parametrised Avalon-MM slave that drives a multiplexed multi-digit seven-segment display. It replaces the single 8-bit display PIO with per-digit data registers, optional hex-to-segment decode, per-digit blanking, global blink, and time-multiplexed digit scanning. It sits on the platform interconnect beside the other PIO slaves and drives the board's segment and digit-select pins directly.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles each digit stays selected; must be ≥ 2.
- SEG_ACTIVE_LOW, 1: if 1, segment outputs are inverted, so a lit segment is driven 0.
- DIG_ACTIVE_LOW, 1: if 1, digit-select outputs are inverted, so the selected digit is driven 0.
- clk  in  1  single system clock; all logic is synchronous to its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero wait states, read latency 0.
- seg_out  out  8  segment outputs; bits 0..6 are a..g, bit 7 is dp.
- dig_sel  out  NUM_DIGITS  digit-select outputs; bit i selects digit i.

## Operation
- A write occurs when chipselect=1, write_n=0 and the address is mapped. Unmapped writes are ignored. Unmapped reads return 0. Unused readdata bits are 0.
- Register map:
  - 0..NUM_DIGITS-1, DIGIT[i] (RW, 8 bits, writedata[7:0]):
    - raw mode: a segment pattern.
    - hex mode: [3:0] is a nibble and [7] is dp.
  - 8, CTRL (RW):
    - [0] enable.
    - [1] hex_mode.
    - [2] blink_en.
    - [15:8] blank_mask; bit i blanks digit i, and bits ≥ NUM_DIGITS read 0.
  - 9, BLINK_PERIOD (RW, 16 bits): scan frames per blink half-period.
  - 10, STATUS (RO):
    - [2:0] current digit index.
    - [3] blink phase.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances.
  - The index wraps from NUM_DIGITS-1 to 0. That wrap is a frame tick.
- Blink:
  - The blink counter counts frame ticks 0..BLINK_PERIOD-1. At terminal count it returns to 0 and the phase toggles.
  - When BLINK_PERIOD=0, the counter and phase are held at 0.
  - Any write to BLINK_PERIOD clears the counter and the phase.
- Segment pattern for the current digit i (active-high, before polarity inversion):
  - If blank_mask[i]=1, or blink_en=1 with phase=1: 0x00.
  - Else in raw mode: DIGIT[i].
  - Else in hex mode: {DIGIT[i][7], hex7(DIGIT[i][3:0])}.
  - hex7 values for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- When enable=0:
  - The prescaler, index, blink counter and phase are held at 0.
  - No digit is selected and all segments are off.
- Register writes remain possible whether or not enable is set.
- Polarity inversion is applied at the output registers, after pattern selection.

## Timing
- Reset values:
  - All registers, counters, index and phase are 0.
  - seg_out is 0xFF if SEG_ACTIVE_LOW=1, else 0x00.
  - dig_sel is all ones if DIG_ACTIVE_LOW=1, else all zeros.
- seg_out and dig_sel are registered and recomputed every cycle. They reflect the state as of the previous edge.
- A write sampled at edge N updates its register at edge N. The outputs reflect the new value after edge N+1.
- Anti-ghost: in the output-register cycle that follows an index change, dig_sel is all inactive and seg_out is all off. The newly indexed digit is then driven for the remaining SCAN_DIV-1 cycles.
- Each digit is therefore lit SCAN_DIV-1 cycles per slot. One frame is NUM_DIGITS×SCAN_DIV cycles.
- NUM_DIGITS=1: the index stays 0, but the slot boundary is still a frame tick and still produces the one-cycle gap.
- Writing enable from 0 to 1: scanning starts with index 0 and prescaler 0. Digit 0 is driven after the next edge.
- Writing enable from 1 to 0: the outputs are inactive after the next edge.
- Reset asserted mid-scan: all outputs go to their reset levels immediately, without waiting for a clock edge.
- Simultaneous events: a write to CTRL or BLINK_PERIOD in the same cycle as a prescaler or frame terminal count takes priority. The write's clear and hold effects win over the counter advance.

## Test plan
- Reset and readback: NUM_DIGITS=4, SCAN_DIV=4, DIGIT0=0x3F, DIGIT1=0x06, CTRL=0x01 (enable, raw mode).
  - While reset is asserted: seg_out=0xFF, dig_sel=4'b1111.
  - After reset releases, reading CTRL returns 0.
- Scan order and gap: with the same setup, dig_sel cycles 1110, 1101, 1011, 0111, and STATUS[2:0] counts 0,1,2,3,0.
  - Each digit is driven for 3 cycles, separated by one cycle of 1111 with seg_out=0xFF.
  - seg_out is 0xC0 while digit 0 is selected.
- Hex mode: CTRL=0x03, DIGIT2=0x8A → seg_out=~0xF7=0x08 while digit 2 is selected.
- Blank and blink:
  - With CTRL=0x0201, digit 1 is selected but seg_out=0xFF.
  - With CTRL=0x05 and BLINK_PERIOD=2, STATUS[3] toggles every 32 cycles, and all segments are off while it reads 1.
- Disable and reset mid-scan:
  - Writing CTRL=0 during digit 2 gives inactive outputs after the next edge, and STATUS reads 0.
  - Asserting reset mid-frame clears all registers to 0 and drives the outputs to their reset levels with no clock edge.
- Bus edges:
  - Reading address 11 returns 0.
  - Writing STATUS has no effect.
  - Writing DIGIT[5] with NUM_DIGITS=4 is ignored.
  - Writing with write_n=1 changes nothing.
